// File: rtl/mu0_io_bus.sv
// MU0 I/O bus: RAM/I-O address decode, a TX FIFO, a single-word RX holding
// register and a status register, with read data timed like the RAM.
module mu0_io_bus #(
    parameter logic [11:0] MEM_TOP  = 12'hEFF,
    parameter int          TX_DEPTH = 4
) (
    input  logic        Clk,
    input  logic        nReset,
    input  logic [11:0] Addr,
    input  logic        Wr,
    input  logic        Rd,
    input  logic [15:0] Din,
    output logic [15:0] Dout,
    output logic        Mem_Wr,
    output logic        Mem_Rd,
    input  logic [15:0] Mem_Data,
    output logic [15:0] Out_Data,
    output logic        Out_Valid,
    input  logic        Out_Ready,
    input  logic [15:0] In_Data,
    input  logic        In_Valid,
    output logic        In_Ready
);

    localparam int PW = (TX_DEPTH > 2) ? $clog2(TX_DEPTH) : 1;
    localparam int CW = PW + 1;

    localparam logic [11:0] ADDR_TX     = 12'hFF0;
    localparam logic [11:0] ADDR_STATUS = 12'hFF1;
    localparam logic [11:0] ADDR_RX     = 12'hFF2;

    logic [15:0]   tx_mem_q [TX_DEPTH];
    logic [15:0]   tx_mem_d [TX_DEPTH];
    logic [PW-1:0] tx_wr_ptr_q, tx_wr_ptr_d;
    logic [PW-1:0] tx_rd_ptr_q, tx_rd_ptr_d;
    logic [CW-1:0] tx_count_q, tx_count_d;
    logic          tx_ovf_q, tx_ovf_d;
    logic          rx_valid_q, rx_valid_d;
    logic [15:0]   rx_data_q, rx_data_d;
    logic          sel_io_q, sel_io_d;
    logic [15:0]   io_rdata_q, io_rdata_d;

    logic          in_ram_s;
    logic          tx_full_s;
    logic          tx_empty_s;
    logic          push_req_s;
    logic          push_s;
    logic          pop_s;
    logic          status_rd_s;
    logic          rx_rd_s;
    logic          rx_cap_s;
    logic [15:0]   status_s;

    // Address decode, status word and handshake outputs
    always_comb begin
        in_ram_s    = (Addr <= MEM_TOP);
        Mem_Wr      = in_ram_s ? Wr : 1'b0;
        Mem_Rd      = in_ram_s ? Rd : 1'b0;
        tx_full_s   = (tx_count_q == CW'(TX_DEPTH));
        tx_empty_s  = (tx_count_q == CW'(0));
        push_req_s  = Wr && !in_ram_s && (Addr == ADDR_TX);
        push_s      = push_req_s && !tx_full_s;
        pop_s       = Out_Valid && Out_Ready;
        status_rd_s = Rd && !in_ram_s && (Addr == ADDR_STATUS);
        rx_rd_s     = Rd && !in_ram_s && (Addr == ADDR_RX);
        rx_cap_s    = In_Valid && In_Ready;
        status_s    = {7'b0000000, 5'(tx_count_q), tx_ovf_q, rx_valid_q,
                       tx_empty_s, tx_full_s};
        Out_Valid   = !tx_empty_s;
        Out_Data    = tx_empty_s ? 16'h0000 : tx_mem_q[tx_rd_ptr_q];
        In_Ready    = !rx_valid_q;
        Dout        = sel_io_q ? io_rdata_q : Mem_Data;
    end

    // Next-state for the TX FIFO, overflow flag and RX holding register
    always_comb begin
        tx_mem_d    = tx_mem_q;
        tx_wr_ptr_d = tx_wr_ptr_q;
        tx_rd_ptr_d = tx_rd_ptr_q;
        tx_count_d  = tx_count_q;
        if (push_s) begin
            tx_mem_d[tx_wr_ptr_q] = Din;
            tx_wr_ptr_d           = tx_wr_ptr_q + PW'(1);
        end else begin
            tx_wr_ptr_d = tx_wr_ptr_q;
        end
        if (pop_s) begin
            tx_rd_ptr_d = tx_rd_ptr_q + PW'(1);
        end else begin
            tx_rd_ptr_d = tx_rd_ptr_q;
        end
        case ({push_s, pop_s})
            2'b10:   tx_count_d = tx_count_q + CW'(1);
            2'b01:   tx_count_d = tx_count_q - CW'(1);
            default: tx_count_d = tx_count_q;
        endcase

        // A fresh overflow wins over the clear from a same-edge status read
        if (push_req_s && tx_full_s) begin
            tx_ovf_d = 1'b1;
        end else if (status_rd_s) begin
            tx_ovf_d = 1'b0;
        end else begin
            tx_ovf_d = tx_ovf_q;
        end

        rx_data_d = rx_data_q;
        if (rx_cap_s) begin
            rx_valid_d = 1'b1;
            rx_data_d  = In_Data;
        end else if (rx_rd_s) begin
            rx_valid_d = 1'b0;
        end else begin
            rx_valid_d = rx_valid_q;
        end
    end

    // I/O read value decode, captured on the falling edge like RAM data
    always_comb begin
        if (in_ram_s) begin
            io_rdata_d = 16'h0000;
        end else begin
            case (Addr)
                ADDR_STATUS: io_rdata_d = status_s;
                ADDR_RX:     io_rdata_d = rx_data_q;
                default:     io_rdata_d = 16'h0000;
            endcase
        end
        if (Rd) begin
            sel_io_d = !in_ram_s;
        end else begin
            sel_io_d   = sel_io_q;
            io_rdata_d = io_rdata_q;
        end
    end

    // Rising-edge state: FIFO, flags and RX register
    always_ff @(posedge Clk or negedge nReset) begin
        if (!nReset) begin
            for (int i = 0; i < TX_DEPTH; i++) begin
                tx_mem_q[i] <= 16'h0000;
            end
            tx_wr_ptr_q <= '0;
            tx_rd_ptr_q <= '0;
            tx_count_q  <= '0;
            tx_ovf_q    <= 1'b0;
            rx_valid_q  <= 1'b0;
            rx_data_q   <= 16'h0000;
        end else begin
            tx_mem_q    <= tx_mem_d;
            tx_wr_ptr_q <= tx_wr_ptr_d;
            tx_rd_ptr_q <= tx_rd_ptr_d;
            tx_count_q  <= tx_count_d;
            tx_ovf_q    <= tx_ovf_d;
            rx_valid_q  <= rx_valid_d;
            rx_data_q   <= rx_data_d;
        end
    end

    // Falling-edge read-data capture
    always_ff @(negedge Clk or negedge nReset) begin
        if (!nReset) begin
            sel_io_q   <= 1'b0;
            io_rdata_q <= 16'h0000;
        end else begin
            sel_io_q   <= sel_io_d;
            io_rdata_q <= io_rdata_d;
        end
    end

endmodule

// File: tb/tb_mu0_io_bus.sv
// Directed self-checking bench for mu0_io_bus with hand-computed expectations.
module tb_mu0_io_bus;

    logic        Clk = 1'b0;
    logic        nReset = 1'b0;
    logic [11:0] Addr = 12'h000;
    logic        Wr = 1'b0;
    logic        Rd = 1'b0;
    logic [15:0] Din = 16'h0000;
    logic [15:0] Dout;
    logic        Mem_Wr;
    logic        Mem_Rd;
    logic [15:0] Mem_Data = 16'hBEEF;
    logic [15:0] Out_Data;
    logic        Out_Valid;
    logic        Out_Ready = 1'b0;
    logic [15:0] In_Data = 16'h0000;
    logic        In_Valid = 1'b0;
    logic        In_Ready;

    int errors = 0;
    int checks = 0;

    mu0_io_bus dut (
        .Clk(Clk), .nReset(nReset), .Addr(Addr), .Wr(Wr), .Rd(Rd), .Din(Din),
        .Dout(Dout), .Mem_Wr(Mem_Wr), .Mem_Rd(Mem_Rd), .Mem_Data(Mem_Data),
        .Out_Data(Out_Data), .Out_Valid(Out_Valid), .Out_Ready(Out_Ready),
        .In_Data(In_Data), .In_Valid(In_Valid), .In_Ready(In_Ready)
    );

    always #5 Clk = ~Clk;

    // Bus cycle helpers: each starts and ends just after a rising edge
    task automatic cpu_read(input logic [11:0] a, output logic [15:0] d, output logic mrd);
        Addr = a; Rd = 1'b1;
        @(negedge Clk); #1;
        d = Dout; mrd = Mem_Rd;
        @(posedge Clk); #1;
        Rd = 1'b0; Addr = 12'h000;
    endtask

    task automatic cpu_write(input logic [11:0] a, input logic [15:0] d, output logic mwr);
        Addr = a; Wr = 1'b1; Din = d;
        #1 mwr = Mem_Wr;
        @(posedge Clk); #1;
        Wr = 1'b0; Addr = 12'h000;
    endtask

    task automatic tx_cycle(input logic w, input logic [15:0] d, input logic rdy);
        Addr = 12'hFF0; Wr = w; Din = d; Out_Ready = rdy;
        @(posedge Clk); #1;
        Wr = 1'b0; Out_Ready = 1'b0; Addr = 12'h000;
    endtask

    task automatic test_reset();
        #12;
        checks++; if (Out_Valid !== 1'b0) begin errors++; $display("FAIL reset_out_valid got %b exp 0", Out_Valid); end
        checks++; if (Out_Data !== 16'h0000) begin errors++; $display("FAIL reset_out_data got %h exp 0000", Out_Data); end
        checks++; if (In_Ready !== 1'b1) begin errors++; $display("FAIL reset_in_ready got %b exp 1", In_Ready); end
        checks++; if (Dout !== 16'hBEEF) begin errors++; $display("FAIL reset_dout got %h exp beef", Dout); end
        @(posedge Clk); #1;
        nReset = 1'b1;
    endtask

    task automatic test_ram_read();
        logic [15:0] d; logic f;
        Mem_Data = 16'h1234;
        cpu_read(12'h005, d, f);
        checks++; if (f !== 1'b1) begin errors++; $display("FAIL ram_mem_rd got %b exp 1", f); end
        checks++; if (d !== 16'h1234) begin errors++; $display("FAIL ram_dout got %h exp 1234", d); end
        cpu_write(12'h100, 16'h4321, f);
        checks++; if (f !== 1'b1) begin errors++; $display("FAIL ram_mem_wr got %b exp 1", f); end
        cpu_read(12'hFF1, d, f);
        checks++; if (f !== 1'b0) begin errors++; $display("FAIL io_mem_rd got %b exp 0", f); end
        checks++; if (d !== 16'h0002) begin errors++; $display("FAIL status_idle got %h exp 0002", d); end
    endtask

    task automatic test_tx_fill();
        logic [15:0] d; logic f;
        for (int i = 1; i <= 4; i++) cpu_write(12'hFF0, 16'hA000 + 16'(i), f);
        checks++; if (f !== 1'b0) begin errors++; $display("FAIL tx_mem_wr got %b exp 0", f); end
        cpu_read(12'hFF1, d, f);
        checks++; if (d !== 16'h0041) begin errors++; $display("FAIL status_full got %h exp 0041", d); end
        checks++; if (Out_Data !== 16'hA001) begin errors++; $display("FAIL tx_head got %h exp a001", Out_Data); end
        cpu_write(12'hFF0, 16'hA005, f);
        cpu_read(12'hFF1, d, f);
        checks++; if (d !== 16'h0049) begin errors++; $display("FAIL status_ovf got %h exp 0049", d); end
        cpu_read(12'hFF1, d, f);
        checks++; if (d !== 16'h0041) begin errors++; $display("FAIL status_ovf_clr got %h exp 0041", d); end
        cpu_read(12'hFF0, d, f);
        checks++; if (d !== 16'h0000) begin errors++; $display("FAIL tx_read got %h exp 0000", d); end
    endtask

    task automatic test_tx_drain();
        logic [15:0] d; logic f;
        logic [15:0] exp_q [4] = '{16'hA001, 16'hA002, 16'hA003, 16'hA004};
        Out_Ready = 1'b1;
        for (int i = 0; i < 4; i++) begin
            checks++; if (Out_Valid !== 1'b1 || Out_Data !== exp_q[i]) begin
                errors++; $display("FAIL drain_%0d got v=%b %h exp v=1 %h", i, Out_Valid, Out_Data, exp_q[i]);
            end
            @(posedge Clk); #1;
        end
        Out_Ready = 1'b0;
        checks++; if (Out_Valid !== 1'b0 || Out_Data !== 16'h0000) begin
            errors++; $display("FAIL drain_empty got v=%b %h exp v=0 0000", Out_Valid, Out_Data);
        end
        cpu_read(12'hFF1, d, f);
        checks++; if (d !== 16'h0002) begin errors++; $display("FAIL status_drained got %h exp 0002", d); end
    endtask

    task automatic test_push_pop();
        logic [15:0] d; logic f;
        for (int i = 1; i <= 4; i++) tx_cycle(1'b1, 16'hB000 + 16'(i), 1'b0);
        tx_cycle(1'b1, 16'hB005, 1'b1);
        cpu_read(12'hFF1, d, f);
        checks++; if (d !== 16'h0038) begin errors++; $display("FAIL full_push_pop got %h exp 0038", d); end
        tx_cycle(1'b0, 16'h0000, 1'b1);
        tx_cycle(1'b1, 16'hB006, 1'b1);
        cpu_read(12'hFF1, d, f);
        checks++; if (d !== 16'h0020) begin errors++; $display("FAIL half_push_pop got %h exp 0020", d); end
        checks++; if (Out_Data !== 16'hB004) begin errors++; $display("FAIL wrap_head0 got %h exp b004", Out_Data); end
        tx_cycle(1'b0, 16'h0000, 1'b1);
        checks++; if (Out_Data !== 16'hB006) begin errors++; $display("FAIL wrap_head1 got %h exp b006", Out_Data); end
        tx_cycle(1'b0, 16'h0000, 1'b1);
        checks++; if (Out_Valid !== 1'b0) begin errors++; $display("FAIL wrap_empty got %b exp 0", Out_Valid); end
    endtask

    task automatic test_rx();
        logic [15:0] d; logic f;
        Mem_Data = 16'h9999;
        In_Valid = 1'b1; In_Data = 16'h5A5A;
        checks++; if (In_Ready !== 1'b1) begin errors++; $display("FAIL rx_ready_idle got %b exp 1", In_Ready); end
        @(posedge Clk); #1;
        In_Data = 16'h1111;
        checks++; if (In_Ready !== 1'b0) begin errors++; $display("FAIL rx_ready_full got %b exp 0", In_Ready); end
        cpu_read(12'hFF1, d, f);
        checks++; if (d !== 16'h0006) begin errors++; $display("FAIL status_rx got %h exp 0006", d); end
        cpu_read(12'hFF2, d, f);
        In_Valid = 1'b0;
        checks++; if (d !== 16'h5A5A) begin errors++; $display("FAIL rx_data got %h exp 5a5a", d); end
        checks++; if (In_Ready !== 1'b1) begin errors++; $display("FAIL rx_ready_after got %b exp 1", In_Ready); end
        cpu_read(12'hFF2, d, f);
        checks++; if (d !== 16'h5A5A) begin errors++; $display("FAIL rx_stale got %h exp 5a5a", d); end
        cpu_write(12'hFF2, 16'hFFFF, f);
        checks++; if (f !== 1'b0) begin errors++; $display("FAIL rx_wr_mem got %b exp 0", f); end
        cpu_write(12'hF00, 16'hFFFF, f);
        checks++; if (f !== 1'b0) begin errors++; $display("FAIL f00_wr_mem got %b exp 0", f); end
        cpu_read(12'hFF5, d, f);
        checks++; if (d !== 16'h0000) begin errors++; $display("FAIL unmapped_rd got %h exp 0000", d); end
        cpu_read(12'hFF1, d, f);
        checks++; if (d !== 16'h0002) begin errors++; $display("FAIL status_nochange got %h exp 0002", d); end
    endtask

    task automatic test_wr_rd();
        logic [15:0] d; logic f;
        Addr = 12'hFF0; Wr = 1'b1; Rd = 1'b1; Din = 16'hC001;
        @(negedge Clk); #1;
        d = Dout;
        @(posedge Clk); #1;
        Wr = 1'b0; Rd = 1'b0;
        checks++; if (d !== 16'h0000) begin errors++; $display("FAIL wr_rd_data got %h exp 0000", d); end
        checks++; if (Out_Valid !== 1'b1 || Out_Data !== 16'hC001) begin
            errors++; $display("FAIL wr_rd_push got v=%b %h exp v=1 c001", Out_Valid, Out_Data);
        end
        cpu_read(12'hFF1, d, f);
        checks++; if (d !== 16'h0010) begin errors++; $display("FAIL status_one got %h exp 0010", d); end
        tx_cycle(1'b0, 16'h0000, 1'b1);
    endtask

    task automatic test_reset_mid();
        logic [15:0] d; logic f;
        tx_cycle(1'b1, 16'hD001, 1'b0);
        tx_cycle(1'b1, 16'hD002, 1'b0);
        In_Valid = 1'b1; In_Data = 16'h7777;
        @(posedge Clk); #1;
        In_Valid = 1'b0;
        cpu_read(12'hFF1, d, f);
        checks++; if (d !== 16'h0024) begin errors++; $display("FAIL status_pre_rst got %h exp 0024", d); end
        Mem_Data = 16'h8888;
        #2 nReset = 1'b0;
        #1;
        checks++; if (Out_Valid !== 1'b0 || Out_Data !== 16'h0000) begin
            errors++; $display("FAIL rst_mid_tx got v=%b %h exp v=0 0000", Out_Valid, Out_Data);
        end
        checks++; if (In_Ready !== 1'b1) begin errors++; $display("FAIL rst_mid_rx got %b exp 1", In_Ready); end
        checks++; if (Dout !== 16'h8888) begin errors++; $display("FAIL rst_mid_dout got %h exp 8888", Dout); end
        @(posedge Clk); #1;
        nReset = 1'b1;
        cpu_read(12'hFF1, d, f);
        checks++; if (d !== 16'h0002) begin errors++; $display("FAIL status_post_rst got %h exp 0002", d); end
    endtask

    initial begin
        test_reset();
        test_ram_read();
        test_tx_fill();
        test_tx_drain();
        test_push_pop();
        test_rx();
        test_wr_rd();
        test_reset_mid();
        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule

// File: doc/mu0_io_bus.md
MU0_IO_BUS -- requirements
Module: mu0_io_bus

Interface
REQ-001 SHALL have parameter MEM_TOP, default 12'hEFF, highest RAM address; addresses above it decode as I/O.
REQ-002 SHALL have parameter TX_DEPTH, default 4, TX FIFO entries (power of two, 2..16).
REQ-003 SHALL have port Clk  input  1  the single system clock.
REQ-004 SHALL have port nReset  input  1  asynchronous, active-low reset.
REQ-005 SHALL have port Addr  input  12  CPU address.
REQ-006 SHALL have port Wr  input  1  CPU write strobe.
REQ-007 SHALL have port Rd  input  1  CPU read strobe.
REQ-008 SHALL have port Din  input  16  CPU write data.
REQ-009 SHALL have port Dout  output  16  read data returned to CPU.
REQ-010 SHALL have port Mem_Wr  output  1  RAM write strobe.
REQ-011 SHALL have port Mem_Rd  output  1  RAM read strobe.
REQ-012 SHALL have port Mem_Data  input  16  RAM read data.
REQ-013 SHALL have port Out_Data  output  16  TX FIFO head word.
REQ-014 SHALL have port Out_Valid  output  1  TX word available.
REQ-015 SHALL have port Out_Ready  input  1  sink accepts TX word.
REQ-016 SHALL have port In_Data  input  16  RX word from source.
REQ-017 SHALL have port In_Valid  input  1  RX word offered.
REQ-018 SHALL have port In_Ready  output  1  RX holding register empty.

Function
REQ-019 Decode, combinational: Addr<=MEM_TOP -> Mem_Wr=Wr, Mem_Rd=Rd; otherwise Mem_Wr=Mem_Rd=0.
REQ-020 Register map: 12'hFF0 TX (write pushes, read returns 0); 12'hFF1 STATUS (read-only); 12'hFF2 RX (read-only); all other I/O addresses read 0, ignore writes.
REQ-021 STATUS: bit0 tx_full, bit1 tx_empty, bit2 rx_valid, bit3 tx_overflow (sticky), bits[8:4] tx_count, bits[15:9] 0.
REQ-022 Read data matches RAM timing: on negedge Clk with Rd=1, a sel_io flag and io_rdata register SHALL capture Addr>MEM_TOP and the decoded I/O value; Dout = sel_io ? io_rdata : Mem_Data.
REQ-023 All other state SHALL update on posedge Clk; read side effects occur at the posedge ending the Rd cycle.
REQ-024 TX push: posedge with Wr, Addr==12'hFF0, !tx_full -> Din written at tail, count+1.
REQ-025 TX push while tx_full: data dropped, tx_overflow set, FIFO unchanged; a simultaneous pop does not make room that edge.
REQ-026 TX pop: posedge with Out_Valid && Out_Ready -> head advances, count-1; Out_Valid = count!=0; Out_Data = head entry (0 when empty).
REQ-027 Simultaneous accepted push and pop: count unchanged, both pointers advance; pointers wrap modulo TX_DEPTH.
REQ-028 STATUS read (posedge, Rd, Addr==12'hFF1) clears tx_overflow; if an overflow occurs the same edge, the bit stays set.
REQ-029 RX: In_Ready = !rx_valid; posedge with In_Valid && In_Ready -> rx_data<=In_Data, rx_valid<=1.
REQ-030 RX read (posedge, Rd, Addr==12'hFF2) clears rx_valid; no capture the same edge (In_Ready low); rx_data retained.
REQ-031 RX read while rx_valid=0 returns the stale rx_data and changes nothing.
REQ-032 Wr and Rd both asserted: write and read effects both occur as specified independently.

Reset
REQ-033 nReset low SHALL immediately clear: TX pointers/count, tx_overflow, rx_valid, rx_data=0, sel_io=0, io_rdata=0; hence Out_Valid=0, Out_Data=0, In_Ready=1, Dout=Mem_Data.
REQ-034 Reset mid-operation SHALL discard FIFO contents and pending RX word; no partial push or pop completes.

Verification
REQ-035 Reset, then read 12'h005 with RAM holding 16'h1234 -> Mem_Rd=1, Dout=16'h1234 after negedge; STATUS read -> 16'h0002.
REQ-036 Write 16'hA001..A004 to FF0, Out_Ready=0 -> STATUS=16'h0041; fifth write 16'hA005 -> dropped, STATUS=16'h0049; next STATUS read -> 16'h0041.
REQ-037 Out_Ready=1 with 4 queued -> Out_Data A001,A002,A003,A004 on successive cycles, then Out_Valid=0, STATUS=16'h0002.
REQ-038 Full FIFO, push and pop same edge -> push dropped, overflow set, count 3; half-full push+pop same edge -> count unchanged, order preserved across pointer wrap.
REQ-039 In_Valid=1, In_Data=16'h5A5A -> In_Ready falls next cycle, STATUS bit2=1; read FF2 -> Dout=16'h5A5A, In_Ready=1 the following cycle; write to FF2 and to 12'hF00 -> RAM untouched, no state change.
REQ-040 Assert nReset low mid-cycle with 2 TX words and rx_valid=1 -> Out_Valid=0, In_Ready=1 without a clock edge; STATUS after release=16'h0002.
